// File: rtl/ika87ad_mcseq_if.sv
// Sequencer <-> decoder/ROM/datapath signal bundle.
// Latency: none; this is wiring only.
// Backpressure: none here; i_WAIT and o_BUSY gate i_CEN inside the sequencer.
interface ika87ad_mcseq_if;
  logic        i_CEN;
  logic        i_WAIT;
  logic        i_DEC_VALID;
  logic [7:0]  i_DEC_ADDR;
  logic        o_MCROM_READ_TICK;
  logic [7:0]  o_MCROM_ADDR;
  logic [17:0] i_MCROM_DATA;
  logic        o_MC_VALID;
  logic [1:0]  o_MC_TYPE;
  logic        o_MC_FLAG;
  logic        o_MC_SKIP;
  logic [11:0] o_MC_OP;
  logic [1:0]  o_MC_BUS;
  logic        o_OPFETCH;
  logic [2:0]  o_STEP;
  logic        o_BUSY;

  // Sequencer side.
  modport master (
    input  i_CEN, i_WAIT, i_DEC_VALID, i_DEC_ADDR, i_MCROM_DATA,
    output o_MCROM_READ_TICK, o_MCROM_ADDR, o_MC_VALID, o_MC_TYPE, o_MC_FLAG,
           o_MC_SKIP, o_MC_OP, o_MC_BUS, o_OPFETCH, o_STEP, o_BUSY
  );

  // Environment side: decoder, ROM and datapath.
  modport slave (
    output i_CEN, i_WAIT, i_DEC_VALID, i_DEC_ADDR, i_MCROM_DATA,
    input  o_MCROM_READ_TICK, o_MCROM_ADDR, o_MC_VALID, o_MC_TYPE, o_MC_FLAG,
           o_MC_SKIP, o_MC_OP, o_MC_BUS, o_OPFETCH, o_STEP, o_BUSY
  );
endinterface

// File: rtl/ika87ad_mcseq.sv
// Microcode sequencer: walks the ROM word stream, decodes the latched word into fields.
// Latency: accepted i_CEN -> tick/addr +1 clock, word latched with o_MC_VALID +2 clocks.
// Backpressure: i_CEN dropped while i_WAIT or a read is in flight (o_BUSY); never queued.
module ika87ad_mcseq (
  input  logic             i_CLK,
  input  logic             i_RST,
  ika87ad_mcseq_if.master  bus
);

  localparam logic [7:0]  IRD_ADDR = 8'hFF;
  localparam logic [1:0]  BUS_RD4  = 2'b10;
  // Type 11 with bus RD4 is the NOP microword shown out of reset.
  localparam logic [17:0] NOP_WORD = 18'h30002;

  typedef enum logic [1:0] {S_RST, S_IRD, S_RUN} state_t;

  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic        tick_q, tick_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic        opfetch_q, opfetch_d;
  logic [17:0] word_q, word_d;
  logic [2:0]  step_q, step_d;
  logic        pend_q, pend_d;
  logic [7:0]  pend_addr_q, pend_addr_d;
  logic        cen_acc;

  // Next-state: decode capture, word latch, and address sequencing on accepted strobes.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    tick_d      = 1'b0;
    valid_d     = 1'b0;
    opfetch_d   = 1'b0;
    busy_d      = valid_q ? 1'b0 : busy_q;
    word_d      = word_q;
    step_d      = step_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    cen_acc     = bus.i_CEN & ~bus.i_WAIT & ~busy_q;

    if (tick_q) begin
      word_d  = bus.i_MCROM_DATA;
      valid_d = 1'b1;
    end

    // Decode pulses during an instruction are not wanted; only IRD consumes them.
    if (bus.i_DEC_VALID && state_q != S_RUN) begin
      pend_d      = 1'b1;
      pend_addr_d = bus.i_DEC_ADDR;
    end

    if (cen_acc) begin
      tick_d = 1'b1;
      busy_d = 1'b1;
      case (state_q)
        S_RST: begin
          addr_d  = IRD_ADDR;
          state_d = S_IRD;
        end
        S_IRD: begin
          if (bus.i_DEC_VALID || pend_q) begin
            addr_d  = bus.i_DEC_VALID ? bus.i_DEC_ADDR : pend_addr_q;
            step_d  = 3'd0;
            pend_d  = 1'b0;
            state_d = S_RUN;
          end else begin
            addr_d = IRD_ADDR;
          end
        end
        S_RUN: begin
          if (word_q[1:0] == BUS_RD4) begin
            opfetch_d = 1'b1;
            addr_d    = IRD_ADDR;
            state_d   = S_IRD;
          end else begin
            addr_d = addr_q + 8'd1;
            if (step_q != 3'd7) step_d = step_q + 3'd1;
          end
        end
        default: state_d = S_RST;
      endcase
    end
  end

  // State register; reset aborts any read in flight and restores the NOP view.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q     <= S_RST;
      addr_q      <= IRD_ADDR;
      tick_q      <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      opfetch_q   <= 1'b0;
      word_q      <= NOP_WORD;
      step_q      <= 3'd0;
      pend_q      <= 1'b0;
      pend_addr_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      tick_q      <= tick_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      opfetch_q   <= opfetch_d;
      word_q      <= word_d;
      step_q      <= step_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  assign bus.o_MCROM_READ_TICK = tick_q;
  assign bus.o_MCROM_ADDR      = addr_q;
  assign bus.o_MC_VALID        = valid_q;
  assign bus.o_MC_TYPE         = word_q[17:16];
  assign bus.o_MC_FLAG         = word_q[15];
  assign bus.o_MC_SKIP         = word_q[14];
  assign bus.o_MC_OP           = word_q[13:2];
  assign bus.o_MC_BUS          = word_q[1:0];
  assign bus.o_OPFETCH         = opfetch_q;
  assign bus.o_STEP            = step_q;
  assign bus.o_BUSY            = busy_q;

endmodule
